// File: rtl/axi4lite_initiator.sv
// ---------------------------------------------------------------------------
// axi4lite_initiator
//
// Single-outstanding AXI4-Lite manager. A command taken on the simple
// request port becomes exactly one AXI4-Lite read or write; the outcome is
// returned as exactly one response on the response port.
//
// Handshake rule used on every channel of this block: a transfer happens on
// the rising clock edge where valid and ready are both high. A valid, once
// raised, stays high with its payload unchanged until that edge. A ready may
// rise or fall freely.
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command request handshake
//   cmd_write                  1 = write, 0 = read
//   cmd_addr                   target address
//   cmd_wdata, cmd_wstrb       write payload (ignored for reads)
//   rsp_valid / rsp_ready      response handshake
//   rsp_write                  echoes cmd_write of the completed command
//   rsp_rdata                  read data (0 for writes)
//   rsp_resp                   BRESP or RRESP as returned by the target
//   i_ctrl_aw*/w*/b*/ar*/r*    AXI4-Lite manager port
//   dbg_state                  current FSM state encoding (observation only)
// ---------------------------------------------------------------------------
module axi4lite_initiator #(
    parameter int addrWidth        = 32,
    parameter int dataWidth        = 32,
    parameter int writeStrobeWidth = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,

    // Command port
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [addrWidth-1:0]        cmd_addr,
    input  logic [dataWidth-1:0]        cmd_wdata,
    input  logic [writeStrobeWidth-1:0] cmd_wstrb,

    // Response port
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_write,
    output logic [dataWidth-1:0]        rsp_rdata,
    output logic [1:0]                  rsp_resp,

    // AXI4-Lite AW channel
    output logic                        i_ctrl_awvalid,
    input  logic                        i_ctrl_awready,
    output logic [addrWidth-1:0]        i_ctrl_awaddr,
    output logic [2:0]                  i_ctrl_awprot,

    // AXI4-Lite W channel
    output logic                        i_ctrl_wvalid,
    input  logic                        i_ctrl_wready,
    output logic [dataWidth-1:0]        i_ctrl_wdata,
    output logic [writeStrobeWidth-1:0] i_ctrl_wstrb,

    // AXI4-Lite B channel
    input  logic                        i_ctrl_bvalid,
    output logic                        i_ctrl_bready,
    input  logic [1:0]                  i_ctrl_bresp,

    // AXI4-Lite AR channel
    output logic                        i_ctrl_arvalid,
    input  logic                        i_ctrl_arready,
    output logic [addrWidth-1:0]        i_ctrl_araddr,
    output logic [2:0]                  i_ctrl_arprot,

    // AXI4-Lite R channel
    input  logic                        i_ctrl_rvalid,
    output logic                        i_ctrl_rready,
    input  logic [dataWidth-1:0]        i_ctrl_rdata,
    input  logic [1:0]                  i_ctrl_rresp,

    // Observation
    output logic [2:0]                  dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,   // AW and/or W still pending
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        RSP   = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    // Per-channel pending flags for the write address/data phase. They are
    // the AW/W valids themselves, so each channel drops independently the
    // cycle after its own handshake.
    logic aw_pend;
    logic aw_pend_next;
    logic w_pend;
    logic w_pend_next;

    // Registered command payload; drives the AXI address/data outputs so
    // they stay stable for the whole transaction.
    logic [addrWidth-1:0]        addr_q;
    logic [dataWidth-1:0]        wdata_q;
    logic [writeStrobeWidth-1:0] wstrb_q;

    // Registered response fields.
    logic                        rsp_write_q;
    logic [dataWidth-1:0]        rsp_rdata_q;
    logic [1:0]                  rsp_resp_q;

    // Handshake strobes
    logic cmd_fire;
    logic aw_fire;
    logic w_fire;
    logic b_fire;
    logic ar_fire;
    logic r_fire;

    assign cmd_fire = (state == IDLE)  && cmd_valid;
    assign aw_fire  = aw_pend          && i_ctrl_awready;
    assign w_fire   = w_pend           && i_ctrl_wready;
    assign b_fire   = (state == WRESP) && i_ctrl_bvalid;
    assign ar_fire  = (state == RADDR) && i_ctrl_arready;
    assign r_fire   = (state == RDATA) && i_ctrl_rvalid;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
        end else begin
            state   <= state_next;
            aw_pend <= aw_pend_next;
            w_pend  <= w_pend_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        aw_pend_next = aw_pend;
        w_pend_next  = w_pend;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next   = cmd_write ? WADDR : RADDR;
                    aw_pend_next = cmd_write;
                    w_pend_next  = cmd_write;
                end
            end

            WADDR: begin
                if (aw_fire) begin
                    aw_pend_next = 1'b0;
                end
                if (w_fire) begin
                    w_pend_next = 1'b0;
                end
                // Both channels done, whether together this cycle or with
                // one of them completed earlier.
                if (!aw_pend_next && !w_pend_next) begin
                    state_next = WRESP;
                end
            end

            WRESP: begin
                if (i_ctrl_bvalid) begin
                    state_next = RSP;
                end
            end

            RADDR: begin
                if (i_ctrl_arready) begin
                    state_next = RDATA;
                end
            end

            RDATA: begin
                if (i_ctrl_rvalid) begin
                    state_next = RSP;
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next   = IDLE;
                aw_pend_next = 1'b0;
                w_pend_next  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Command payload capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (cmd_fire) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
        end
    end

    // -----------------------------------------------------------------------
    // Response capture. Fields change only on a B/R handshake, so they are
    // stable for the whole time rsp_valid is high.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else if (b_fire) begin
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= i_ctrl_bresp;
        end else if (r_fire) begin
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= i_ctrl_rdata;
            rsp_resp_q  <= i_ctrl_rresp;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: all are flops or decodes of the state register, so none
    // depends combinationally on an input.
    // -----------------------------------------------------------------------
    assign cmd_ready      = (state == IDLE);
    assign rsp_valid      = (state == RSP);
    assign rsp_write      = rsp_write_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_resp       = rsp_resp_q;

    assign i_ctrl_awvalid = aw_pend;
    assign i_ctrl_awaddr  = addr_q;
    assign i_ctrl_awprot  = 3'b000;

    assign i_ctrl_wvalid  = w_pend;
    assign i_ctrl_wdata   = wdata_q;
    assign i_ctrl_wstrb   = wstrb_q;

    assign i_ctrl_bready  = (state == WRESP);

    assign i_ctrl_arvalid = (state == RADDR);
    assign i_ctrl_araddr  = addr_q;
    assign i_ctrl_arprot  = 3'b000;

    assign i_ctrl_rready  = (state == RDATA);

    assign dbg_state      = state;

endmodule

// File: tb/tb_axi4lite_initiator.sv
// ---------------------------------------------------------------------------
// tb_axi4lite_initiator
//
// Directed bench for axi4lite_initiator. The AXI target is played by the
// stimulus sequence itself, one cycle at a time, so every wait is a fixed
// number of cycles. Inputs change and outputs are sampled 1 time unit after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_axi4lite_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_RSP   = 3'd5;

  logic          clk = 1'b0;
  logic          reset_n;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  logic          awvalid, awready;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          wvalid, wready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          rvalid, rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic [2:0]    dbg_state;

  int compared   = 0;
  int mismatched = 0;

  // Register-model target storage, word indexed
  logic [DW-1:0] reg_model [0:15];
  logic [AW-1:0] rd_addr;

  axi4lite_initiator #(
    .addrWidth       (AW),
    .dataWidth       (DW),
    .writeStrobeWidth(SW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_write     (rsp_write),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .i_ctrl_awvalid(awvalid),
    .i_ctrl_awready(awready),
    .i_ctrl_awaddr (awaddr),
    .i_ctrl_awprot (awprot),
    .i_ctrl_wvalid (wvalid),
    .i_ctrl_wready (wready),
    .i_ctrl_wdata  (wdata),
    .i_ctrl_wstrb  (wstrb),
    .i_ctrl_bvalid (bvalid),
    .i_ctrl_bready (bready),
    .i_ctrl_bresp  (bresp),
    .i_ctrl_arvalid(arvalid),
    .i_ctrl_arready(arready),
    .i_ctrl_araddr (araddr),
    .i_ctrl_arprot (arprot),
    .i_ctrl_rvalid (rvalid),
    .i_ctrl_rready (rready),
    .i_ctrl_rdata  (rdata),
    .i_ctrl_rresp  (rresp),
    .dbg_state     (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
  endtask

  task automatic clear_cmd();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
  endtask

  // Consume the pending response and check the block is back in IDLE
  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_drop"}, rsp_valid, 0);
    chk({tag, "_cmd_ready_back"}, cmd_ready, 1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_write"}, rsp_write, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_resp"},  rsp_resp,  0);
    chk({tag, "_axi_valids_readies"},
        {awvalid, wvalid, bready, arvalid, rready}, 5'b00000);
    chk({tag, "_awaddr"}, awaddr, 0);
    chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_wdata"},  wdata,  0);
    chk({tag, "_wstrb"},  wstrb,  0);
    chk({tag, "_prot"},   {awprot, arprot}, 6'b000000);
    chk({tag, "_state"},  dbg_state, S_IDLE);
  endtask

  initial begin
    reset_n   = 1'b0;
    rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0;   rresp = 2'b00;
    clear_cmd();
    for (int i = 0; i < 16; i++) reg_model[i] = '0;

    // ---------------- reset ----------------
    tick();
    tick();
    chk_reset_values("rst");
    reset_n = 1'b1;
    tick();
    chk_reset_values("post_rst");

    // ---------------- write, zero-wait target ----------------
    drive_cmd(1'b1, 32'h0, 32'h3A5, 4'hF);
    awready = 1'b1; wready = 1'b1;
    tick();                                   // accept at N
    clear_cmd();
    chk("w0_awvalid", awvalid, 1);
    chk("w0_wvalid",  wvalid,  1);
    chk("w0_awaddr",  awaddr,  32'h0);
    chk("w0_wdata",   wdata,   32'h3A5);
    chk("w0_wstrb",   wstrb,   4'hF);
    chk("w0_cmd_ready_low", cmd_ready, 0);
    chk("w0_bready_low", bready, 0);
    tick();                                   // AW+W at N+1
    awready = 1'b0; wready = 1'b0;
    chk("w0_valids_drop", {awvalid, wvalid}, 2'b00);
    chk("w0_bready", bready, 1);
    chk("w0_no_rsp_yet", rsp_valid, 0);
    bvalid = 1'b1; bresp = 2'b00;
    tick();                                   // B at N+2
    bvalid = 1'b0;
    chk("w0_rsp_valid_n3", rsp_valid, 1);
    chk("w0_rsp_write", rsp_write, 1);
    chk("w0_rsp_resp",  rsp_resp,  2'b00);
    chk("w0_rsp_rdata", rsp_rdata, 0);
    chk("w0_bready_off", bready, 0);
    consume("w0");

    // ---------------- split AW/W ----------------
    drive_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'h3);
    awready = 1'b1; wready = 1'b0;
    tick();
    clear_cmd();
    chk("sp_awvalid", awvalid, 1);
    chk("sp_wvalid",  wvalid,  1);
    tick();                                   // AW only
    awready = 1'b0;
    chk("sp_awvalid_drop", awvalid, 0);
    chk("sp_wvalid_held", wvalid, 1);
    chk("sp_bready_low", bready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sp_wait_wvalid", wvalid, 1);
      chk("sp_wait_wdata",  wdata,  32'hDEADBEEF);
      chk("sp_wait_wstrb",  wstrb,  4'h3);
      chk("sp_wait_awvalid", awvalid, 0);
      chk("sp_wait_bready", bready, 0);
      chk("sp_wait_state", dbg_state, S_WADDR);
    end
    wready = 1'b1;
    tick();                                   // W handshake
    wready = 1'b0;
    chk("sp_wvalid_drop", wvalid, 0);
    chk("sp_bready", bready, 1);
    chk("sp_state_wresp", dbg_state, S_WRESP);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk("sp_rsp_valid", rsp_valid, 1);
    chk("sp_rsp_write", rsp_write, 1);
    consume("sp");

    // ---------------- read with stalls ----------------
    drive_cmd(1'b0, 32'h8, 32'h0, 4'h0);
    arready = 1'b0;
    tick();
    clear_cmd();
    chk("rd_arvalid_1", arvalid, 1);
    chk("rd_araddr_1",  araddr,  32'h8);
    chk("rd_no_aw", {awvalid, wvalid}, 2'b00);
    chk("rd_cmd_ready_low", cmd_ready, 0);
    tick();
    chk("rd_arvalid_2", arvalid, 1);
    chk("rd_araddr_2",  araddr,  32'h8);
    tick();
    chk("rd_arvalid_3", arvalid, 1);
    chk("rd_araddr_3",  araddr,  32'h8);
    arready = 1'b1;
    tick();                                   // AR handshake
    arready = 1'b0;
    chk("rd_arvalid_drop", arvalid, 0);
    chk("rd_rready", rready, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rd_wait_rready", rready, 1);
      chk("rd_wait_no_rsp", rsp_valid, 0);
      chk("rd_wait_state", dbg_state, S_RDATA);
    end
    rvalid = 1'b1; rdata = 32'h000001FF; rresp = 2'b00;
    tick();
    rvalid = 1'b0; rdata = '0;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h1FF);
    chk("rd_rsp_write", rsp_write, 0);
    chk("rd_rsp_resp",  rsp_resp,  2'b00);
    chk("rd_rready_off", rready, 0);
    consume("rd");

    // ---------------- error and backpressure ----------------
    drive_cmd(1'b1, 32'hC, 32'h55, 4'hF);
    awready = 1'b1; wready = 1'b1;
    tick();
    clear_cmd();
    tick();
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = 2'b10;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    drive_cmd(1'b0, 32'h20, 32'h0, 4'h0);     // must not be taken
    for (int i = 0; i < 5; i++) begin
      chk("er_rsp_valid", rsp_valid, 1);
      chk("er_rsp_resp",  rsp_resp,  2'b10);
      chk("er_rsp_write", rsp_write, 1);
      chk("er_rsp_rdata", rsp_rdata, 0);
      chk("er_cmd_ready", cmd_ready, 0);
      chk("er_no_arvalid", arvalid, 0);
      chk("er_state", dbg_state, S_RSP);
      tick();
    end
    clear_cmd();
    consume("er");

    // ---------------- back-to-back ----------------
    drive_cmd(1'b1, 32'h4, 32'h3, 4'hF);
    awready = 1'b1; wready = 1'b1;
    tick();
    clear_cmd();
    if (awvalid && wvalid) reg_model[awaddr[5:2]] = wdata;
    tick();
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk("bb_w_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    drive_cmd(1'b0, 32'h4, 32'h0, 4'h0);
    tick();                                   // response handshake at K
    rsp_ready = 1'b0;
    chk("bb_rsp_drop", rsp_valid, 0);
    chk("bb_cmd_ready_k1", cmd_ready, 1);
    chk("bb_not_early", arvalid, 0);
    arready = 1'b1;
    tick();                                   // accept at K+1
    clear_cmd();
    chk("bb_arvalid", arvalid, 1);
    chk("bb_araddr",  araddr,  32'h4);
    chk("bb_cmd_ready_low", cmd_ready, 0);
    rd_addr = araddr;
    tick();                                   // AR handshake
    arready = 1'b0;
    rvalid = 1'b1; rdata = reg_model[rd_addr[5:2]]; rresp = 2'b00;
    tick();
    rvalid = 1'b0; rdata = '0;
    chk("bb_rsp_valid", rsp_valid, 1);
    chk("bb_rsp_rdata", rsp_rdata, 32'h3);
    chk("bb_rsp_write", rsp_write, 0);
    consume("bb");

    // ---------------- reset mid-write ----------------
    drive_cmd(1'b1, 32'h18, 32'hAB, 4'hF);
    awready = 1'b1; wready = 1'b1;
    tick();
    clear_cmd();
    tick();
    awready = 1'b0; wready = 1'b0;
    chk("rw_in_wresp", dbg_state, S_WRESP);
    chk("rw_bready", bready, 1);
    chk("rw_awaddr", awaddr, 32'h18);
    reset_n = 1'b0;
    #1;                                       // no clock edge in between
    chk_reset_values("rw_async");
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rw_no_rsp", rsp_valid, 0);
      chk("rw_idle", cmd_ready, 1);
    end
    drive_cmd(1'b0, 32'h24, 32'h0, 4'h0);
    arready = 1'b1;
    tick();
    clear_cmd();
    chk("rw_rd_arvalid", arvalid, 1);
    chk("rw_rd_araddr",  araddr,  32'h24);
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hCAFE0001; rresp = 2'b00;
    tick();
    rvalid = 1'b0; rdata = '0;
    chk("rw_rd_rsp_valid", rsp_valid, 1);
    chk("rw_rd_rdata", rsp_rdata, 32'hCAFE0001);
    chk("rw_rd_write", rsp_write, 0);
    consume("rw");

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
